// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle control sequencer: state codes, one-hot op bit indices
// in ISA order (add..jal at 0..30), and trap cause codes.
package mc_pkg;

    localparam int OP_W = 31;

    localparam logic [2:0] ST_IF   = 3'd0;
    localparam logic [2:0] ST_ID   = 3'd1;
    localparam logic [2:0] ST_EX   = 3'd2;
    localparam logic [2:0] ST_MEM  = 3'd3;
    localparam logic [2:0] ST_WB   = 3'd4;
    localparam logic [2:0] ST_TRAP = 3'd5;

    localparam int OP_ADD  = 0;
    localparam int OP_ADDU = 1;
    localparam int OP_JR   = 16;
    localparam int OP_LW   = 22;
    localparam int OP_SW   = 23;
    localparam int OP_BEQ  = 24;
    localparam int OP_BNE  = 25;
    localparam int OP_J    = 29;
    localparam int OP_JAL  = 30;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_BUS     = 2'd2;

endpackage

// File: rtl/mc_sequencer_onehot_chk.sv
// Purpose: flags whether the decoded op vector has exactly one bit set.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of op.
module mc_onehot_chk
    import mc_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output logic            legal
);

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign legal = (op != '0) && ((op & (op - OP_W'(1))) == '0);

endmodule

// File: rtl/mc_sequencer.sv
// Purpose: IF/ID/EX/MEM/WB control sequencer driving PC, IR, regfile and dram strobes, plus counters.
// Latency: 2 (jumps), 3 (branches), 4 (ALU, sw), 5 (lw) cycles, plus run=0 stalls and MEM waits.
// Backpressure: run=0 holds in IF; MEM holds until mem_ready or traps after MEM_TIMEOUT cycles.
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [30:0]      op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             imem_r,
    output logic             ir_we,
    output logic             pc_we,
    output logic             br_take,
    output logic             rf_we,
    output logic             dm_cs,
    output logic             dm_r,
    output logic             dm_w,
    output logic [2:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    logic       legal;
    logic [2:0] nxt_state;
    logic [1:0] nxt_cause;
    logic       retire;
    logic [7:0] stb;
    logic [7:0] wait_cnt;
    logic       mem_timeout;

    mc_onehot_chk u_onehot_chk (
        .op    (op),
        .legal (legal)
    );

    assign mem_timeout = (wait_cnt == 8'(MEM_TIMEOUT - 1));

    // stb bit order: imem_r, ir_we, pc_we, br_take, rf_we, dm_cs, dm_r, dm_w
    always_comb begin
        stb       = '0;
        nxt_state = state;
        nxt_cause = trap_cause;
        retire    = 1'b0;
        case (state)
            ST_IF: begin
                if (run) begin
                    stb[7:6]  = 2'b11;
                    nxt_state = ST_ID;
                end
            end
            ST_ID: begin
                if (!legal) begin
                    nxt_state = ST_TRAP;
                    nxt_cause = CAUSE_ILLEGAL;
                end else if (op[OP_J] || op[OP_JR] || op[OP_JAL]) begin
                    stb[5]    = 1'b1;
                    stb[3]    = op[OP_JAL];
                    retire    = 1'b1;
                    nxt_state = ST_IF;
                end else begin
                    nxt_state = ST_EX;
                end
            end
            ST_EX: begin
                if (op[OP_BEQ] || op[OP_BNE]) begin
                    stb[5]    = 1'b1;
                    stb[4]    = (op[OP_BEQ] & zero) | (op[OP_BNE] & ~zero);
                    retire    = 1'b1;
                    nxt_state = ST_IF;
                end else if (op[OP_LW] || op[OP_SW]) begin
                    nxt_state = ST_MEM;
                end else begin
                    nxt_state = ST_WB;
                end
            end
            ST_MEM: begin
                // A ready arriving on the last allowed cycle still completes the access.
                if (mem_ready || !mem_timeout) begin
                    stb[2:0] = {1'b1, op[OP_LW], op[OP_SW]};
                end
                if (mem_ready) begin
                    if (op[OP_LW]) begin
                        nxt_state = ST_WB;
                    end else begin
                        stb[5]    = 1'b1;
                        retire    = 1'b1;
                        nxt_state = ST_IF;
                    end
                end else if (mem_timeout) begin
                    nxt_state = ST_TRAP;
                    nxt_cause = CAUSE_BUS;
                end
            end
            ST_WB: begin
                stb[5]    = 1'b1;
                stb[3]    = 1'b1;
                retire    = 1'b1;
                nxt_state = ST_IF;
            end
            default: begin
            end
        endcase
    end

    assign {imem_r, ir_we, pc_we, br_take, rf_we, dm_cs, dm_r, dm_w} = rst ? 8'd0 : stb;
    assign trap = (state == ST_TRAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IF;
            trap_cause <= CAUSE_NONE;
            wait_cnt   <= '0;
            cycle_cnt  <= '0;
            instr_cnt  <= '0;
        end else begin
            state      <= nxt_state;
            trap_cause <= nxt_cause;
            if (state != ST_MEM) begin
                wait_cnt <= '0;
            end else if (!mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (state != ST_TRAP) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (retire) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

endmodule
